draw_column: RTL and testbench

DRAW_COLUMN -- requirements
Module: draw_column

---
 rtl/draw_column_pkg.sv | 16 +
 rtl/column_segment_sel.sv | 25 ++
 rtl/draw_column.sv | 147 ++++++++++++++
 tb/tb_draw_column.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/draw_column_pkg.sv
// Shared definitions for the column renderer: FSM encoding and default geometry.
package draw_column_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOUR_W = 18;
  localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/column_segment_sel.sv
// Picks the colour of one pixel of a column from its row relative to the wall span.
module column_segment_sel
  import draw_column_pkg::*;
#(
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W
) (
  input  logic [Y_W-1:0]      y,
  input  logic [Y_W-1:0]      top,
  input  logic [Y_W-1:0]      bottom,
  input  logic [COLOUR_W-1:0] ceil_colour,
  input  logic [COLOUR_W-1:0] wall_colour,
  input  logic [COLOUR_W-1:0] floor_colour,
  output logic [COLOUR_W-1:0] colour
);

  always_comb begin
    colour = wall_colour;
    if (y < top)
      colour = ceil_colour;
    else if (y > bottom)
      colour = floor_colour;
  end

endmodule

// File: rtl/draw_column.sv
// Streams one vertical column of pixels (wall only, or ceiling/wall/floor) to a
// ready/valid VGA adapter.
module draw_column
  import draw_column_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      wall_top,
  input  logic [Y_W-1:0]      wall_bottom,
  input  logic                mode,
  input  logic [COLOUR_W-1:0] ceil_colour,
  input  logic [COLOUR_W-1:0] wall_colour,
  input  logic [COLOUR_W-1:0] floor_colour,
  input  logic                vga_ready,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_write
);

  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  state_t              state;
  logic [Y_W-1:0]      curr_y;
  logic [Y_W-1:0]      end_y;

  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      top_raw_q;
  logic [Y_W-1:0]      bot_raw_q;
  logic                mode_q;
  logic [COLOUR_W-1:0] ceil_q;
  logic [COLOUR_W-1:0] wall_q;
  logic [COLOUR_W-1:0] floor_q;

  logic [Y_W-1:0]      top_cl;
  logic [Y_W-1:0]      bot_cl;
  logic [Y_W-1:0]      top_c;
  logic [Y_W-1:0]      bot_c;
  logic [Y_W-1:0]      y_first;
  logic [Y_W-1:0]      y_last;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_colour;

  // Request capture: data registers only, so they carry no reset.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && start) begin
      x_q       <= x;
      top_raw_q <= wall_top;
      bot_raw_q <= wall_bottom;
      mode_q    <= mode;
      ceil_q    <= ceil_colour;
      wall_q    <= wall_colour;
      floor_q   <= floor_colour;
    end
  end

  // Clamp each end to the screen, then order them so top <= bottom.
  always_comb begin
    top_cl  = clamp_y(top_raw_q);
    bot_cl  = clamp_y(bot_raw_q);
    top_c   = (top_cl > bot_cl) ? bot_cl : top_cl;
    bot_c   = (top_cl > bot_cl) ? top_cl : bot_cl;
    y_first = mode_q ? '0 : top_c;
    y_last  = mode_q ? Y_MAX : bot_c;
    // Colour is registered alongside the row it belongs to, so select ahead.
    sel_y   = (state == S_LOAD) ? y_first : curr_y + Y_W'(1);
  end

  column_segment_sel #(
    .Y_W      (Y_W),
    .COLOUR_W (COLOUR_W)
  ) u_seg_sel (
    .y            (sel_y),
    .top          (top_c),
    .bottom       (bot_c),
    .ceil_colour  (ceil_q),
    .wall_colour  (wall_q),
    .floor_colour (floor_q),
    .colour       (sel_colour)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_write  <= 1'b0;
      vga_x      <= '0;
      vga_colour <= '0;
      curr_y     <= '0;
      end_y      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          state      <= S_EMIT;
          curr_y     <= y_first;
          end_y      <= y_last;
          vga_x      <= x_q;
          vga_colour <= sel_colour;
          vga_write  <= 1'b1;
        end
        S_EMIT: begin
          // Without ready every pixel output simply holds.
          if (vga_ready) begin
            if (curr_y == end_y) begin
              state     <= S_DONE;
              vga_write <= 1'b0;
              done      <= 1'b1;
            end else begin
              curr_y     <= curr_y + Y_W'(1);
              vga_colour <= sel_colour;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign vga_y = curr_y;

endmodule

// File: tb/tb_draw_column.sv
// Directed and randomized column draws checked against a list-of-pixels model.
module tb_draw_column;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int CW  = 18;
  localparam int H   = 120;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] wall_top;
  logic [Y_W-1:0] wall_bottom;
  logic          mode;
  logic [CW-1:0] ceil_colour;
  logic [CW-1:0] wall_colour;
  logic [CW-1:0] floor_colour;
  logic          vga_ready;
  logic          busy;
  logic          done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_write;

  draw_column #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .COLOUR_W (CW),
    .SCREEN_H (H)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .x            (x),
    .wall_top     (wall_top),
    .wall_bottom  (wall_bottom),
    .mode         (mode),
    .ceil_colour  (ceil_colour),
    .wall_colour  (wall_colour),
    .floor_colour (floor_colour),
    .vga_ready    (vga_ready),
    .busy         (busy),
    .done         (done),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_write    (vga_write)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int y;
    int c;
  } pix_t;
  pix_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected pixel stream straight from the drawing rules.
  task automatic build_model(input int t_in, input int b_in, input int m,
                             input int cc, input int wc, input int fc);
    int t, b, tmp;
    pix_t p;
    t = (t_in > H - 1) ? H - 1 : t_in;
    b = (b_in > H - 1) ? H - 1 : b_in;
    if (t > b) begin
      tmp = t; t = b; b = tmp;
    end
    exp_q.delete();
    for (int y = (m != 0 ? 0 : t); y <= (m != 0 ? H - 1 : b); y++) begin
      p.y = y;
      p.c = (y < t) ? cc : (y > b) ? fc : wc;
      exp_q.push_back(p);
    end
  endtask

  // Called #1 after a rising edge; leaves time at the same phase.
  task automatic run_draw(input int xi, input int ti, input int bi, input int mi,
                          input bit rand_ready, input int stall_y,
                          input bit busy_start, input int abort_pix,
                          input int want_done_k);
    int cc, wc, fc, n, idx, k, stalls, stall_left;
    bit in_emit, rdy, finished;
    cc = int'($urandom_range(0, (1 << CW) - 1));
    wc = int'($urandom_range(0, (1 << CW) - 1));
    fc = int'($urandom_range(0, (1 << CW) - 1));
    build_model(ti, bi, mi, cc, wc, fc);
    n = exp_q.size();
    x = X_W'(xi); wall_top = Y_W'(ti); wall_bottom = Y_W'(bi); mode = mi[0];
    ceil_colour = CW'(cc); wall_colour = CW'(wc); floor_colour = CW'(fc);
    start = 1'b1; vga_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    // Later input changes must not disturb the draw in progress.
    x = X_W'($urandom); wall_top = Y_W'($urandom); wall_bottom = Y_W'($urandom);
    mode = 1'($urandom); ceil_colour = CW'($urandom); wall_colour = CW'($urandom);
    floor_colour = CW'($urandom);
    k = 1; idx = 0; stalls = 0; stall_left = 3; finished = 1'b0;
    while (k < 600 && !finished) begin
      in_emit = (k >= 2) && (idx < n);
      chk("vga_write", vga_write, in_emit);
      chk("busy", busy, 1);
      chk("done", done, (k >= 2) && (idx == n));
      if (in_emit) begin
        chk("vga_x", vga_x, xi);
        chk("vga_y", vga_y, exp_q[idx].y);
        chk("vga_colour", vga_colour, exp_q[idx].c);
      end
      if (abort_pix >= 0 && in_emit && idx == abort_pix) begin
        start = 1'b0; reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_write", vga_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(posedge clock); #1;
          chk("post_rst_idle", {vga_write, done, busy}, 0);
        end
        return;
      end
      if ((k >= 2) && (idx == n)) begin
        finished = 1'b1;
        chk("done_cycle", k, 2 + n + stalls);
        if (want_done_k > 0) chk("done_latency", k, want_done_k);
      end else begin
        if (in_emit && vga_y == Y_W'(stall_y) && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (in_emit && !rdy) stalls++;
        vga_ready = rdy;
        start = (busy_start && k == 3);
        if (start) begin
          x = X_W'(xi + 1); wall_top = 7'd0; wall_bottom = 7'd100; mode = 1'b1;
        end
        @(posedge clock); #1;
        if (in_emit && rdy) idx++;
        k++;
      end
    end
    if (!finished) chk("timeout", 0, 1);
    start = 1'b0;
    @(posedge clock); #1;
    chk("after_done", {vga_write, done, busy}, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; x = '0; wall_top = '0; wall_bottom = '0; mode = 1'b0;
    ceil_colour = '0; wall_colour = '0; floor_colour = '0; vga_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl", {busy, done, vga_write}, 0);
    chk("reset_xyc", {vga_x, vga_y, vga_colour}, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("idle_busy", busy, 0);

    run_draw(10, 20, 23, 0, 1'b0, -1, 1'b0, -1, 6);
    run_draw(int'($urandom_range(0, 255)), 50, 59, 1, 1'b0, -1, 1'b0, -1, 122);
    run_draw(77, 30, 25, 0, 1'b0, -1, 1'b0, -1, 8);
    run_draw(3, 127, 127, 0, 1'b0, -1, 1'b0, -1, 3);
    run_draw(10, 20, 23, 0, 1'b0, 21, 1'b0, -1, 9);

    for (int i = 0; i < 8; i++)
      run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 127)), int'($urandom_range(0, 1)),
               1'b1, -1, 1'b0, -1, 0);

    run_draw(5, 10, 40, 0, 1'b0, -1, 1'b1, 2, 0);
    run_draw(200, 0, 0, 0, 1'b1, -1, 1'b0, -1, 0);
    run_draw(201, 100, 119, 1, 1'b1, -1, 1'b0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
